// File: rtl/agc_pkg.sv
// rtl/agc_pkg.sv - shared types and widths for the AGC measurement controller
package agc_pkg;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TICK    = 3'd1,
    ST_RUN     = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_SETTLE  = 3'd5
  } agc_state_t;

  localparam int SCALE_W     = 17;
  localparam int OFFSET_W    = 16;
  localparam int SQ_BITS_DEF = 24;
  localparam int PR_BITS_DEF = 21;

endpackage

// File: rtl/agc_window_timer.sv
// rtl/agc_window_timer.sv - tick/run/flush counter for one measurement window
module agc_window_timer #(
  parameter int PERIOD_LOG2 = 17,
  parameter int ACC_LAT     = 3
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic tick_st_i,
  input  logic run_st_i,
  input  logic flush_st_i,
  output logic agc_tick_o,
  output logic agc_ce_o,
  output logic run_last_o,
  output logic flush_last_o
);

  localparam int CW = PERIOD_LOG2 + 1;
  localparam logic [CW-1:0] RUN_MAX   = CW'((1 << PERIOD_LOG2) - 1);
  localparam logic [CW-1:0] FLUSH_MAX = CW'(ACC_LAT - 1);

  logic [CW-1:0] cnt_q;

  // Phase strobes and last-cycle flags decoded from the shared counter
  always_comb begin
    agc_tick_o   = tick_st_i;
    agc_ce_o     = run_st_i;
    run_last_o   = run_st_i && (cnt_q == RUN_MAX);
    flush_last_o = flush_st_i && (cnt_q == FLUSH_MAX);
  end

  // Count through RUN, restart at zero for FLUSH, hold at zero otherwise
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if ((run_st_i && !run_last_o) || (flush_st_i && !flush_last_o)) begin
      cnt_q <= cnt_q + CW'(1);
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/agc_measure_ctrl.sv
// rtl/agc_measure_ctrl.sv - AGC measurement sequencer and gain/offset loader
module agc_measure_ctrl
  import agc_pkg::*;
#(
  parameter int SQ_BITS     = SQ_BITS_DEF,
  parameter int PR_BITS     = PR_BITS_DEF,
  parameter int PERIOD_LOG2 = 17,
  parameter int ACC_LAT     = 3,
  parameter int SETTLE      = 8
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                enable_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  input  logic [SQ_BITS-1:0]  sq_accum_i,
  input  logic [PR_BITS-1:0]  gt_accum_i,
  input  logic [PR_BITS-1:0]  lt_accum_i,
  output logic [SQ_BITS-1:0]  sq_o,
  output logic [PR_BITS-1:0]  gt_o,
  output logic [PR_BITS-1:0]  lt_o,
  output logic                agc_tick_o,
  output logic                agc_ce_o,
  output logic                agc_rst_o,
  input  logic                lfsr_resync_i,
  input  logic [SCALE_W-1:0]  scale_i,
  input  logic                scale_wr_i,
  input  logic [OFFSET_W-1:0] offset_i,
  input  logic                offset_wr_i,
  input  logic                apply_req_i,
  output logic [SCALE_W-1:0]  agc_scale_o,
  output logic [OFFSET_W-1:0] agc_offset_o,
  output logic                agc_scale_ce_o,
  output logic                agc_offset_ce_o,
  output logic                agc_apply_o
);

  localparam int SW = $clog2(SETTLE + 1);

  agc_state_t         state_q, state_d, exit_st;
  logic               pending_q;
  logic               apply_now;
  logic [SW-1:0]      settle_cnt_q;
  logic               settle_done;
  logic               run_last, flush_last;
  logic [SQ_BITS-1:0] sq_q;
  logic [PR_BITS-1:0] gt_q, lt_q;

  agc_window_timer #(
    .PERIOD_LOG2 (PERIOD_LOG2),
    .ACC_LAT     (ACC_LAT)
  ) u_timer (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .tick_st_i    (state_q == ST_TICK),
    .run_st_i     (state_q == ST_RUN),
    .flush_st_i   (state_q == ST_FLUSH),
    .agc_tick_o   (agc_tick_o),
    .agc_ce_o     (agc_ce_o),
    .run_last_o   (run_last),
    .flush_last_o (flush_last)
  );

  // A same-cycle write delays the apply by one cycle so its ce lands first
  assign apply_now   = pending_q || (apply_req_i && !scale_wr_i && !offset_wr_i);
  assign exit_st     = apply_now ? ST_SETTLE : ST_IDLE;
  assign settle_done = (settle_cnt_q == SW'(SETTLE));

  // State and pending-apply registers; pending clears on entry to SETTLE
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= (state_d == ST_SETTLE && state_q != ST_SETTLE) ? 1'b0
                                                                    : (pending_q || apply_req_i);
    end
  end

  // Next-state: apply beats start in IDLE; enable low abandons the window
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (apply_now)                                   state_d = ST_SETTLE;
        else if (start_i && enable_i && !apply_req_i)    state_d = ST_TICK;
      end
      ST_TICK:    state_d = !enable_i ? exit_st : ST_RUN;
      ST_RUN: begin
        if (!enable_i)     state_d = exit_st;
        else if (run_last) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!enable_i)       state_d = exit_st;
        else if (flush_last) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: state_d = exit_st;
      ST_SETTLE:  if (settle_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; captured values pass through during CAPTURE
  always_comb begin
    busy_o      = (state_q != ST_IDLE);
    done_o      = (state_q == ST_CAPTURE);
    agc_apply_o = (state_q == ST_SETTLE) && (settle_cnt_q == '0);
    sq_o        = (state_q == ST_CAPTURE) ? sq_accum_i : sq_q;
    gt_o        = (state_q == ST_CAPTURE) ? gt_accum_i : gt_q;
    lt_o        = (state_q == ST_CAPTURE) ? lt_accum_i : lt_q;
  end

  // SETTLE dwell counter; the first SETTLE cycle carries the apply pulse
  always_ff @(posedge clk_i) begin
    if (!rstn_i || state_q != ST_SETTLE) settle_cnt_q <= '0;
    else                                 settle_cnt_q <= settle_cnt_q + SW'(1);
  end

  // Hold the accumulator snapshot between captures
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sq_q <= '0;
      gt_q <= '0;
      lt_q <= '0;
    end else if (state_q == ST_CAPTURE) begin
      sq_q <= sq_accum_i;
      gt_q <= gt_accum_i;
      lt_q <= lt_accum_i;
    end
  end

  // Host-side gain/offset staging and LFSR resync, independent of the FSM
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      agc_scale_o     <= '0;
      agc_offset_o    <= '0;
      agc_scale_ce_o  <= 1'b0;
      agc_offset_ce_o <= 1'b0;
      agc_rst_o       <= 1'b0;
    end else begin
      if (scale_wr_i)  agc_scale_o  <= scale_i;
      if (offset_wr_i) agc_offset_o <= offset_i;
      agc_scale_ce_o  <= scale_wr_i;
      agc_offset_ce_o <= offset_wr_i;
      agc_rst_o       <= lfsr_resync_i;
    end
  end

endmodule

// File: tb/tb_agc_measure_ctrl.sv
// tb/tb_agc_measure_ctrl.sv - self-checking bench for agc_measure_ctrl
module tb_agc_measure_ctrl;

  localparam int PL   = 4;
  localparam int ACC  = 3;
  localparam int SETL = 8;
  localparam int NW   = 1 << PL;
  localparam int CAP  = NW + ACC + 2;

  logic        clk = 1'b0;
  logic        rstn, enable, start, apply_req, resync, scale_wr, offset_wr;
  logic [23:0] sq_acc;
  logic [20:0] gt_acc, lt_acc;
  logic [16:0] scale_in;
  logic [15:0] offset_in;
  logic        busy_o, done_o, agc_tick_o, agc_ce_o, agc_rst_o;
  logic        agc_scale_ce_o, agc_offset_ce_o, agc_apply_o;
  logic [23:0] sq_o;
  logic [20:0] gt_o, lt_o;
  logic [16:0] agc_scale_o;
  logic [15:0] agc_offset_o;

  agc_measure_ctrl #(
    .SQ_BITS(24), .PR_BITS(21), .PERIOD_LOG2(PL), .ACC_LAT(ACC), .SETTLE(SETL)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .enable_i(enable), .start_i(start),
    .busy_o(busy_o), .done_o(done_o),
    .sq_accum_i(sq_acc), .gt_accum_i(gt_acc), .lt_accum_i(lt_acc),
    .sq_o(sq_o), .gt_o(gt_o), .lt_o(lt_o),
    .agc_tick_o(agc_tick_o), .agc_ce_o(agc_ce_o), .agc_rst_o(agc_rst_o),
    .lfsr_resync_i(resync),
    .scale_i(scale_in), .scale_wr_i(scale_wr),
    .offset_i(offset_in), .offset_wr_i(offset_wr),
    .apply_req_i(apply_req),
    .agc_scale_o(agc_scale_o), .agc_offset_o(agc_offset_o),
    .agc_scale_ce_o(agc_scale_ce_o), .agc_offset_ce_o(agc_offset_ce_o),
    .agc_apply_o(agc_apply_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference model: window and settle periods kept as start timestamps
  bit          mvalid = 0;
  int          win_t, app_t;
  bit          pend;
  logic [23:0] m_sq;
  logic [20:0] m_gt, m_lt;
  logic [16:0] m_scale;
  logic [15:0] m_offset;
  bit          m_sce, m_oce, m_rst;
  bit          e_tick, e_ce, e_done, e_apply, e_busy, fin, wr, ap_now;

  int tick_cnt = 0, done_cnt = 0, apply_cnt = 0, ce_cnt = 0;
  int last_tick = -1, last_done = -1, last_apply = -1;

  always @(negedge clk) begin
    if (mvalid) begin
      e_tick  = (win_t >= 0) && (cyc == win_t + 1);
      e_ce    = (win_t >= 0) && (cyc >= win_t + 2) && (cyc <= win_t + 1 + NW);
      e_done  = (win_t >= 0) && (cyc == win_t + CAP);
      e_apply = (app_t >= 0) && (cyc == app_t);
      e_busy  = (win_t >= 0) || (app_t >= 0);
      check_eq("busy", busy_o, e_busy);
      check_eq("tick", agc_tick_o, e_tick);
      check_eq("ce", agc_ce_o, e_ce);
      check_eq("done", done_o, e_done);
      check_eq("apply", agc_apply_o, e_apply);
      check_eq("sq", sq_o, e_done ? sq_acc : m_sq);
      check_eq("gt", gt_o, e_done ? gt_acc : m_gt);
      check_eq("lt", lt_o, e_done ? lt_acc : m_lt);
      check_eq("scale", agc_scale_o, m_scale);
      check_eq("offset", agc_offset_o, m_offset);
      check_eq("scale_ce", agc_scale_ce_o, m_sce);
      check_eq("offset_ce", agc_offset_ce_o, m_oce);
      check_eq("agc_rst", agc_rst_o, m_rst);
      if (agc_tick_o)  begin tick_cnt++;  last_tick  = cyc; end
      if (done_o)      begin done_cnt++;  last_done  = cyc; end
      if (agc_apply_o) begin apply_cnt++; last_apply = cyc; end
      if (agc_ce_o)    ce_cnt++;
    end
    if (!rstn) begin
      mvalid = 1; win_t = -1; app_t = -1; pend = 0;
      m_sq = '0; m_gt = '0; m_lt = '0; m_scale = '0; m_offset = '0;
      m_sce = 0; m_oce = 0; m_rst = 0;
    end else if (mvalid) begin
      wr     = scale_wr || offset_wr;
      ap_now = pend || (apply_req && !wr);
      m_sce = scale_wr; m_oce = offset_wr; m_rst = resync;
      if (scale_wr)  m_scale  = scale_in;
      if (offset_wr) m_offset = offset_in;
      if (win_t >= 0) begin
        fin = 0;
        if (cyc == win_t + CAP) begin
          m_sq = sq_acc; m_gt = gt_acc; m_lt = lt_acc; fin = 1;
        end else if (!enable) begin
          fin = 1;
        end
        if (fin) begin
          win_t = -1;
          if (ap_now) begin app_t = cyc + 1; pend = 0; end
          else if (apply_req) pend = 1;
        end else if (apply_req) pend = 1;
      end else if (app_t >= 0) begin
        if (apply_req) pend = 1;
        if (cyc == app_t + SETL) app_t = -1;
      end else begin
        if (ap_now) begin app_t = cyc + 1; pend = 0; end
        else if (apply_req) pend = 1;
        else if (start && enable) win_t = cyc;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int t0, k0;

  initial begin
    rstn = 0; enable = 1; start = 0; apply_req = 0; resync = 0;
    scale_wr = 0; offset_wr = 0; scale_in = '0; offset_in = '0;
    sq_acc = 24'h123456; gt_acc = 21'h0abcd; lt_acc = 21'h01234;
    step(3);
    rstn = 1;
    check_eq("reset_busy", busy_o, 0);
    check_eq("reset_sq", sq_o, 0);
    step(2);

    // Basic window
    t0 = cyc; k0 = ce_cnt;
    start = 1; step(1); start = 0;
    step(25);
    check_eq("basic_tick_cyc", last_tick, t0 + 1);
    check_eq("basic_done_cyc", last_done, t0 + 2 + NW + ACC);
    check_eq("basic_ce_count", ce_cnt - k0, NW);
    check_eq("basic_sq", sq_o, 24'h123456);

    // Abort during RUN
    sq_acc = 24'habcdef; k0 = done_cnt; t0 = cyc;
    start = 1; step(1); start = 0;
    step(9);
    enable = 0; step(1); enable = 1;
    check_eq("abort_busy", busy_o, 0);
    check_eq("abort_ce", agc_ce_o, 0);
    step(25);
    check_eq("abort_no_done", done_cnt - k0, 0);
    check_eq("abort_sq_hold", sq_o, 24'h123456);

    // Deferred apply during RUN
    t0 = cyc; k0 = tick_cnt;
    start = 1; step(1); start = 0;
    step(5);
    apply_req = 1; step(1); apply_req = 0;
    step(15);
    check_eq("defer_apply_now", agc_apply_o, 1);
    check_eq("defer_after_done", last_done, t0 + CAP);
    step(2);
    start = 1; step(1); start = 0;
    step(5);
    check_eq("defer_busy_end", busy_o, 1);
    step(1);
    check_eq("defer_idle", busy_o, 0);
    step(5);
    check_eq("defer_start_drop", tick_cnt - k0, 1);

    // Idle apply with simultaneous write
    scale_in = 17'h1000; scale_wr = 1; apply_req = 1;
    step(1); scale_wr = 0; apply_req = 0;
    check_eq("wa_scale_ce", agc_scale_ce_o, 1);
    check_eq("wa_apply_early", agc_apply_o, 0);
    check_eq("wa_scale", agc_scale_o, 17'h1000);
    step(1);
    check_eq("wa_apply", agc_apply_o, 1);
    step(12);

    // Start and apply together in IDLE
    k0 = tick_cnt;
    start = 1; apply_req = 1; step(1); start = 0; apply_req = 0;
    check_eq("coll_apply", agc_apply_o, 1);
    check_eq("coll_tick", agc_tick_o, 0);
    step(12);
    check_eq("coll_no_tick", tick_cnt - k0, 0);

    // Reset mid-window with an apply pending
    start = 1; step(1); start = 0;
    step(4);
    apply_req = 1; step(1); apply_req = 0;
    step(2);
    rstn = 0; step(1); rstn = 1;
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_ce", agc_ce_o, 0);
    check_eq("rst_sq", sq_o, 0);
    check_eq("rst_scale", agc_scale_o, 0);
    k0 = apply_cnt;
    step(20);
    check_eq("rst_pend_clr", apply_cnt - k0, 0);
    start = 1; step(1); start = 0;
    check_eq("rst_restart_tick", agc_tick_o, 1);
    step(25);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rstn      = ($urandom_range(0, 599) != 0);
      enable    = ($urandom_range(0, 79) != 0);
      start     = ($urandom_range(0, 7) == 0);
      apply_req = ($urandom_range(0, 31) == 0);
      scale_wr  = ($urandom_range(0, 15) == 0);
      offset_wr = ($urandom_range(0, 15) == 0);
      resync    = ($urandom_range(0, 15) == 0);
      scale_in  = 17'($urandom);
      offset_in = 16'($urandom);
      sq_acc    = 24'($urandom);
      gt_acc    = 21'($urandom);
      lt_acc    = 21'($urandom);
      step(1);
    end
    rstn = 1; enable = 1; start = 0; apply_req = 0;
    scale_wr = 0; offset_wr = 0; resync = 0;
    step(40);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
